// File: rtl/if_id_pkg.sv
// Shared widths, NOP encoding and payload/field types for the IF/ID stage
// and any tooling (e.g. the disassembly monitor) that decodes its contents.
package if_id_pkg;

    localparam int DEF_INSTR_W = 16;
    localparam int DEF_PC_W    = 8;
    localparam int DEF_OPC_W   = 5;
    localparam int DEF_REG_W   = 3;
    localparam int DEF_IMM_W   = 5;
    localparam int DEF_CNT_W   = 16;

    localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_PC_W-1:0]    pcp1;
    } if_id_payload_t;

    typedef struct packed {
        logic [DEF_OPC_W-1:0] opcode;
        logic [DEF_REG_W-1:0] rs;
        logic [DEF_REG_W-1:0] rt;
        logic [DEF_REG_W-1:0] rd;
        logic [DEF_IMM_W-1:0] imm5;
        logic [DEF_PC_W-1:0]  jaddr;
    } if_id_fields_t;

endpackage

// File: rtl/if_id_field_decode.sv
// Combinational ISA field extraction; an invalid word decodes as NOP_INSTR.
// Fields overlap deliberately: imm5 aliases rd, jaddr aliases rt/rd.
module if_id_field_decode
    import if_id_pkg::*;
#(
    parameter int                 INSTR_W   = DEF_INSTR_W,
    parameter int                 PC_W      = DEF_PC_W,
    parameter int                 OPC_W     = DEF_OPC_W,
    parameter int                 REG_W     = DEF_REG_W,
    parameter int                 IMM_W     = DEF_IMM_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic               valid,
    input  logic [INSTR_W-1:0] instr,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rt,
    output logic [REG_W-1:0]   rd,
    output logic [IMM_W-1:0]   imm5,
    output logic [PC_W-1:0]    jaddr
);

    logic [INSTR_W-1:0] word;

    assign word   = valid ? instr : NOP_INSTR;
    assign opcode = word[INSTR_W-1 -: OPC_W];
    assign rs     = word[INSTR_W-OPC_W-1 -: REG_W];
    assign rt     = word[INSTR_W-OPC_W-REG_W-1 -: REG_W];
    assign rd     = word[INSTR_W-OPC_W-2*REG_W-1 -: REG_W];
    assign imm5   = word[IMM_W-1:0];
    assign jaddr  = word[PC_W-1:0];

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer so in_ready is purely
// registered; supports flush, NOP substitution and a saturating stall counter.
module if_id_skid_reg
    import if_id_pkg::*;
#(
    parameter int                 INSTR_W   = DEF_INSTR_W,
    parameter int                 PC_W      = DEF_PC_W,
    parameter int                 OPC_W     = DEF_OPC_W,
    parameter int                 REG_W     = DEF_REG_W,
    parameter int                 IMM_W     = DEF_IMM_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR,
    parameter int                 CNT_W     = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pcp1,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rt,
    output logic [REG_W-1:0]   rd,
    output logic [IMM_W-1:0]   imm5,
    output logic [PC_W-1:0]    jaddr,
    output logic [PC_W-1:0]    pcp1_out,
    output logic [CNT_W-1:0]   stall_cnt
);

    if (OPC_W + 3*REG_W > INSTR_W) begin : g_bad_fields
        $error("if_id_skid_reg: OPC_W + 3*REG_W exceeds INSTR_W");
    end
    if (IMM_W > INSTR_W) begin : g_bad_imm
        $error("if_id_skid_reg: IMM_W exceeds INSTR_W");
    end
    if (PC_W > INSTR_W) begin : g_bad_pc
        $error("if_id_skid_reg: PC_W exceeds INSTR_W");
    end

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pcp1;
    } payload_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic       main_vld_p1;
    logic       skid_vld_p1;
    payload_t   main_pay_p1;
    payload_t   skid_pay_p1;
    payload_t   in_pay;
    logic [CNT_W-1:0] stall_cnt_p1;
    logic       accept;
    logic       load_main;

    assign in_pay    = '{instr: in_instr, pcp1: in_pcp1};
    assign in_ready  = !skid_vld_p1;
    assign accept    = in_valid && in_ready;
    assign load_main = !main_vld_p1 || out_ready;

    // ---- fetch -> IF/ID register boundary (main + skid) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_p1  <= 1'b0;
            skid_vld_p1  <= 1'b0;
            main_pay_p1  <= '0;
            skid_pay_p1  <= '0;
            stall_cnt_p1 <= '0;
        end else begin
            if (main_vld_p1 && !out_ready)
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);

            if (flush) begin
                main_vld_p1 <= 1'b0;
                skid_vld_p1 <= 1'b0;
            end else if (load_main) begin
                if (skid_vld_p1) begin
                    main_pay_p1 <= skid_pay_p1;
                    main_vld_p1 <= 1'b1;
                    skid_vld_p1 <= accept;
                    if (accept)
                        skid_pay_p1 <= in_pay;
                end else if (accept) begin
                    main_pay_p1 <= in_pay;
                    main_vld_p1 <= 1'b1;
                end else begin
                    main_vld_p1 <= 1'b0;
                end
            end else if (accept) begin
                skid_pay_p1 <= in_pay;
                skid_vld_p1 <= 1'b1;
            end
        end
    end

    // ---- IF/ID register -> decode outputs ----
    assign out_valid = main_vld_p1;
    assign pcp1_out  = main_vld_p1 ? main_pay_p1.pcp1 : '0;
    assign stall_cnt = stall_cnt_p1;

    if_id_field_decode #(
        .INSTR_W   (INSTR_W),
        .PC_W      (PC_W),
        .OPC_W     (OPC_W),
        .REG_W     (REG_W),
        .IMM_W     (IMM_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_decode (
        .valid  (main_vld_p1),
        .instr  (main_pay_p1.instr),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .imm5   (imm5),
        .jaddr  (jaddr)
    );

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Parametrised IF/ID pipeline stage with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, NOP bubble insertion and a saturating stall counter.
- Sits between the fetch stage (upstream producer of instruction and PC+1) and the decode stage (downstream consumer of the extracted fields).
- Lets fetch and decode stall independently without combinational ready paths back through the stage.

Parameters:
- INSTR_W, 16, instruction width in bits
- PC_W, 8, PC+1 width in bits; also the jaddr width
- OPC_W, 5, opcode field width
- REG_W, 3, register specifier width (rs/rt/rd)
- IMM_W, 5, immediate field width
- NOP_INSTR, 16'h0000, instruction word presented when out_valid=0
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept; registered (equals !skid_valid)
- in_instr  in  INSTR_W  fetched instruction
- in_pcp1  in  PC_W  PC+1 of the fetched instruction
- flush  in  1  discard all held and incoming entries (branch/jump taken)
- out_valid  out  1  decode fields are valid
- out_ready  in  1  decode consumes this cycle
- opcode  out  OPC_W  instr[INSTR_W-1 -: OPC_W]
- rs  out  REG_W  next REG_W bits below opcode
- rt  out  REG_W  next REG_W bits below rs
- rd  out  REG_W  next REG_W bits below rt
- imm5  out  IMM_W  instr[IMM_W-1:0]
- jaddr  out  PC_W  instr[PC_W-1:0]
- pcp1_out  out  PC_W  PC+1 of the held instruction
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready

Behaviour:
- State:
  - main register {main_valid, instr, pcp1}
  - skid register {skid_valid, instr, pcp1}
  - stall_cnt
- Reset (rst=1 at posedge): main_valid=0, skid_valid=0, both payloads=0, stall_cnt=0.
- Values after reset: in_ready=1, out_valid=0, fields decode NOP_INSTR, pcp1_out=0.
- Handshakes:
  - Accept = in_valid && in_ready.
  - Deliver = out_valid && out_ready.
  - out_valid = main_valid.
- Main register loads when !main_valid or Deliver:
  - From skid if skid_valid (skid_valid then clears, unless the same-cycle Accept refills it).
  - Otherwise from the input if Accept.
  - Otherwise main_valid goes to 0.
- Skid register:
  - Accept while main_valid && !out_ready writes the skid (skid_valid goes to 1).
  - Accept while the skid is occupied cannot happen, because in_ready=0.
- Latency: an accepted instruction appears on the outputs the next cycle when the stage was empty.
- Throughput: 1/cycle sustained with out_ready=1.
- Order: strict FIFO order. No drop, no duplicate.
- Full: skid_valid=1 means in_ready=0 in the following cycle.
  - in_ready depends only on registers, never on out_ready or in_valid.
- Flush:
  - Next cycle main_valid=0 and skid_valid=0.
  - Any same-cycle Accept is discarded.
  - A Deliver in the flush cycle still counts as delivered.
  - Priority: rst > flush > normal operation.
- Invalid output:
  - When out_valid=0, all decoded fields come from NOP_INSTR and pcp1_out=0.
  - Payload registers may keep stale data internally.
- Field decode is combinational from the main payload.
  - Fields overlap exactly as the ISA defines: imm5 shares bits with rd, jaddr shares bits with rt/rd.
- stall_cnt:
  - +1 each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1.
  - Only rst clears it; flush does not.
- Reset mid-transfer drops all held entries. No partial state survives.
- Elaboration asserts:
  - OPC_W + 3*REG_W <= INSTR_W
  - IMM_W <= INSTR_W
  - PC_W <= INSTR_W

Decomposition:
- Package if_id_pkg holds:
  - default widths
  - NOP_INSTR
  - typedef if_id_payload_t {instr, pcp1}
  - typedef if_id_fields_t {opcode, rs, rt, rd, imm5, jaddr}
- One sub-module: if_id_field_decode, combinational, mapping instr to if_id_fields_t (NOP substitution included). It is reused by the disassembly monitor.

Test Plan:
- Reset, then idle -> out_valid=0, in_ready=1, opcode=0, pcp1_out=0, stall_cnt=0.
- in_instr=16'hA9D3, in_pcp1=8'h05, in_valid=1, out_ready=1 -> next cycle:
  - out_valid=1, opcode=5'h15, rs=3'h1, rt=3'h6, rd=3'h4
  - imm5=5'h13, jaddr=8'hD3, pcp1_out=8'h05
- Stream of 8 instructions with out_ready=0 for 2 cycles mid-stream:
  - in_ready drops the cycle after the skid fills.
  - All 8 delivered in order.
  - stall_cnt=2.
- Main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming instruction never delivered.
- CNT_W=4, out_ready=0 held for 20 cycles with a valid entry -> stall_cnt stops at 15.
- rst pulsed while skid is full -> next cycle out_valid=0, in_ready=1, stall_cnt=0.
